// File: rtl/spike_shift_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spike_shift_scheduler_if                                                   |
// | Requester, shared-shifter and response bundle for spike_shift_scheduler.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface spike_shift_scheduler_if #(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int NUM_REQ       = 4
);
  localparam int SW  = 2 * MAX_SHIFT_MAG + 1;
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*LEN-1:0] req_spikes;
  logic [NUM_REQ*SW-1:0]  req_shift;
  logic [LEN-1:0]         sh_ip;
  logic [SW-1:0]          sh_shift;
  logic [LEN-1:0]         sh_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [LEN-1:0]         rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_err;

  modport master (
    output req_valid, req_spikes, req_shift, sh_op, rsp_ready,
    input  req_ready, sh_ip, sh_shift, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_spikes, req_shift, sh_op, rsp_ready,
    output req_ready, sh_ip, sh_shift, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/spike_shift_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spike_shift_scheduler                                                      |
// | Round-robin time-sharing of one combinational spike shifter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spike_shift_scheduler #(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int NUM_REQ       = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  spike_shift_scheduler_if.slave       bus,
  output logic                         busy
);
  localparam int SW  = 2 * MAX_SHIFT_MAG + 1;
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic           r_err;
  logic [LEN-1:0] r_sh_ip;
  logic [SW-1:0]  r_sh_shift;
  logic [LEN-1:0] r_rsp_data;
  logic [IDW-1:0] r_rsp_id;
  logic           r_rsp_err;

  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_accept;
  logic [LEN-1:0] w_sel_spikes;
  logic [SW-1:0]  w_sel_shift;
  logic           w_sel_err;

  // Scan from the pointer downward in offset so the smallest offset wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (IDW + 1)'(i);
      if (w_sum >= (IDW + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW + 1)'(NUM_REQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_spikes = '0;
    w_sel_shift  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == IDW'(k)) begin
        w_sel_spikes = bus.req_spikes[k*LEN +: LEN];
        w_sel_shift  = bus.req_shift[k*SW +: SW];
      end
    end
    w_sel_err = ($countones(w_sel_shift) != 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // req_ready is gated by rst_n so no grant is offered while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    bus.req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found && rst_n) begin
          w_accept               = 1'b1;
          bus.req_ready[w_grant] = 1'b1;
          w_state_nxt            = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_err      <= 1'b0;
      r_sh_ip    <= '0;
      r_sh_shift <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh_ip    <= w_sel_spikes;
            r_sh_shift <= w_sel_err ? '0 : w_sel_shift;
            r_id       <= w_grant;
            r_err      <= w_sel_err;
            r_ptr      <= (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
          end
        end
        S_ISSUE: begin
          r_rsp_data <= r_err ? '0 : bus.sh_op;
          r_rsp_err  <= r_err;
          r_rsp_id   <= r_id;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_sh_ip    <= '0;
            r_sh_shift <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sh_ip     = r_sh_ip;
  assign bus.sh_shift  = r_sh_shift;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_spike_shift_scheduler.sv
`default_nettype none
// Bench for spike_shift_scheduler: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spike_shift_scheduler;
  localparam int LEN     = 8;
  localparam int MAX     = 2;
  localparam int NUM_REQ = 4;
  localparam int SW      = 2 * MAX + 1;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  spike_shift_scheduler_if #(.LEN(LEN), .MAX_SHIFT_MAG(MAX), .NUM_REQ(NUM_REQ)) bus ();

  spike_shift_scheduler #(.LEN(LEN), .MAX_SHIFT_MAG(MAX), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared shifter: slot 0 is the MSB of both the spike and the shift field,
  // positive magnitude delays spikes to later slots.
  function automatic logic [LEN-1:0] shift_model(input logic [LEN-1:0] ip, input logic [SW-1:0] sh);
    int mag;
    shift_model = '0;
    if ($countones(sh) == 1) begin
      for (int p = 0; p < SW; p++) begin
        if (sh[p]) begin
          mag = MAX - p;
          shift_model = (mag >= 0) ? (ip >> mag) : (ip << (-mag));
        end
      end
    end
  endfunction

  assign bus.sh_op = shift_model(bus.sh_ip, bus.sh_shift);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: a requester queue/pointer model of the scheduler.
  initial begin : compare
    int             m_ptr;
    bit             m_busy;
    int             m_age;
    int             m_id;
    int             g;
    logic [LEN-1:0] m_ip, m_data;
    logic [SW-1:0]  m_sh, sh;
    bit             m_err;
    logic [NUM_REQ-1:0] exp_ready;
    m_ptr = 0; m_busy = 0; m_age = 0; m_id = 0;
    m_ip = '0; m_data = '0; m_sh = '0; m_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0;
        m_ptr  = 0;
        check("m_rst_valid", bus.rsp_valid, 0);
        check("m_rst_busy", busy, 0);
        check("m_rst_ready", bus.req_ready, 0);
        check("m_rst_ship", bus.sh_ip, 0);
        continue;
      end
      g = -1;
      exp_ready = '0;
      if (!m_busy) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (g < 0 && bus.req_valid[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("m_req_ready", bus.req_ready, exp_ready);
      check("m_busy", busy, m_busy);
      check("m_rsp_valid", bus.rsp_valid, (m_busy && m_age >= 2));
      if (!m_busy) begin
        check("m_idle_ship", bus.sh_ip, 0);
        check("m_idle_shsh", bus.sh_shift, 0);
      end else if (m_age == 1) begin
        check("m_issue_ship", bus.sh_ip, m_ip);
        check("m_issue_shsh", bus.sh_shift, m_sh);
      end else begin
        check("m_rsp_id", bus.rsp_id, m_id);
        check("m_rsp_data", bus.rsp_data, m_data);
        check("m_rsp_err", bus.rsp_err, m_err);
      end
      if (!m_busy) begin
        if (g >= 0) begin
          sh     = bus.req_shift[g*SW +: SW];
          m_ip   = bus.req_spikes[g*LEN +: LEN];
          m_err  = ($countones(sh) != 1);
          m_sh   = m_err ? '0 : sh;
          m_data = m_err ? '0 : shift_model(m_ip, sh);
          m_id   = g;
          m_busy = 1;
          m_age  = 1;
          m_ptr  = (g + 1) % NUM_REQ;
        end
      end else if (m_age >= 2 && bus.rsp_ready) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  task automatic present(input int k, input logic [LEN-1:0] sp, input logic [SW-1:0] sh);
    bus.req_spikes[k*LEN +: LEN] = sp;
    bus.req_shift[k*SW +: SW]    = sh;
  endtask

  task automatic issue(input int k);
    bus.req_valid    = '0;
    bus.req_valid[k] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int ids[6];
    int tcyc[6];
    int got;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_spikes = '0;
    bus.req_shift  = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_sh_shift", bus.sh_shift, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request: t=1 delayed by +1 lands on t=2
    present(1, 8'b0100_0000, 5'b00010);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("single_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check("single_latency", lat, 2);
    check("single_id", bus.rsp_id, 1);
    check("single_data", bus.rsp_data, 8'b0010_0000);
    check("single_err", bus.rsp_err, 0);
    finish_rsp();
    check("single_idle", busy, 0);

    // Illegal shifts from requester 2
    present(2, 8'hFF, 5'b01010);
    issue(2);
    wait_rsp(lat);
    check("ill2_id", bus.rsp_id, 2);
    check("ill2_err", bus.rsp_err, 1);
    check("ill2_data", bus.rsp_data, 0);
    finish_rsp();
    present(2, 8'h81, 5'b00000);
    issue(2);
    wait_rsp(lat);
    check("ill0_err", bus.rsp_err, 1);
    check("ill0_data", bus.rsp_data, 0);
    finish_rsp();

    // Pointer wrap: ptr=3, requesters 0 and 3 pending
    present(0, 8'b0000_0011, 5'b10000);
    present(3, 8'b1000_0000, 5'b00100);
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("wrap_ready3", bus.req_ready, 4'b1000);
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    wait_rsp(lat);
    check("wrap_id3", bus.rsp_id, 3);
    check("wrap_data3", bus.rsp_data, 8'b1000_0000);
    finish_rsp();
    @(negedge clk);
    check("wrap_ready0", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check("wrap_id0", bus.rsp_id, 0);
    check("wrap_data0", bus.rsp_data, 8'b0000_1100);
    finish_rsp();

    // Back-pressure, with requester 2 waiting
    bus.rsp_ready = 1'b0;
    present(1, 8'b0001_0000, 5'b01000);
    issue(1);
    wait_rsp(lat);
    @(posedge clk); #1;
    present(2, 8'b0000_1000, 5'b00100);
    bus.req_valid = 4'b0100;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_id", bus.rsp_id, 1);
      check("bp_data", bus.rsp_data, 8'b0010_0000);
      check("bp_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_ready", bus.req_ready, 4'b0100);
    check("bp_after_busy", busy, 0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check("bp_next_lat", lat, 2);
    check("bp_next_id", bus.rsp_id, 2);
    check("bp_next_data", bus.rsp_data, 8'b0000_1000);
    finish_rsp();

    // Reset while holding a response
    bus.rsp_ready = 1'b0;
    present(1, 8'b0000_0100, 5'b00001);
    present(3, 8'b0100_0000, 5'b00100);
    issue(1);
    wait_rsp(lat);
    check("rr_pre_id", bus.rsp_id, 1);
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    #1 rst_n = 1'b0;
    #1;
    check("rr_valid", bus.rsp_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_ship", bus.sh_ip, 0);
    check("rr_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rr_first_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    check("rr_id", bus.rsp_id, 1);
    check("rr_data", bus.rsp_data, 8'b0000_0001);
    finish_rsp();

    // Fairness from a fresh pointer, all requesters continuously valid
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    present(0, 8'b1000_0000, 5'b00100);
    present(1, 8'b0100_0000, 5'b00010);
    present(2, 8'b0010_0000, 5'b01000);
    present(3, 8'b0001_0000, 5'b00001);
    bus.req_valid = 4'b1111;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      ids[i]  = -1;
      tcyc[i] = 0;
    end
    for (int n = 0; n < 40 && got < 6; n++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids[got]  = int'(bus.rsp_id);
        tcyc[got] = cyc;
        got++;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    check("fair_count", got, 6);
    for (int i = 0; i < 6; i++) check("fair_id", ids[i], i % NUM_REQ);
    for (int i = 1; i < 6; i++) check("fair_gap", tcyc[i] - tcyc[i-1], 3);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
